// File: rtl/avr_mul_pkg.sv
// Shared types, constants and operand-class helpers for the AVR multiplier.
package avr_mul_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULS   = 3'd1,
    OP_MULSU  = 3'd2,
    OP_FMUL   = 3'd3,
    OP_FMULS  = 3'd4,
    OP_FMULSU = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } mul_state_t;

  localparam logic [4:0] MUL_DST_ADR = 5'd0;

  function automatic logic is_legal(input mul_op_t op);
    case (op)
      OP_RSV6, OP_RSV7: is_legal = 1'b0;
      default:          is_legal = 1'b1;
    endcase
  endfunction

  function automatic logic is_signed_a(input mul_op_t op);
    case (op)
      OP_MULS, OP_MULSU, OP_FMULS, OP_FMULSU: is_signed_a = 1'b1;
      default:                                is_signed_a = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input mul_op_t op);
    case (op)
      OP_MULS, OP_FMULS: is_signed_b = 1'b1;
      default:           is_signed_b = 1'b0;
    endcase
  endfunction

  function automatic logic is_frac(input mul_op_t op);
    case (op)
      OP_FMUL, OP_FMULS, OP_FMULSU: is_frac = 1'b1;
      default:                      is_frac = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/avr_mul_unit_mul_step.sv
// Combinational partial-product step: adds BITS shifted copies of the
// multiplicand, gated by the multiplier slice, into the accumulator.
module mul_step #(
  parameter int BITS = 4
) (
  input  logic [15:0]     acc_i,
  input  logic [15:0]     mcand_i,
  input  logic [BITS-1:0] slice_i,
  output logic [15:0]     acc_o
);

  logic [15:0] sum_s;

  // Unsigned shift-add over the slice; magnitudes keep the sum within 16 bits
  always_comb begin
    sum_s = acc_i;
    for (int k = 0; k < BITS; k++) begin
      if (slice_i[k]) begin
        sum_s = sum_s + (mcand_i << k);
      end else begin
        sum_s = sum_s;
      end
    end
    acc_o = sum_s;
  end

endmodule

// File: rtl/avr_mul_unit.sv
// Multi-cycle 8x8 multiplier (MUL/MULS/MULSU/FMUL/FMULS/FMULSU) writing the
// product to R1:R0 and returning C/Z; sign handled by magnitude + final negate.
module avr_mul_unit
  import avr_mul_pkg::*;
#(
  parameter int BITS_PER_CYC = 4
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic       cp2en,
  input  logic       start,
  input  logic       flush,
  input  logic [2:0] op_sel,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       busy,
  output logic       done,
  output logic       reg_rd_wr,
  output logic       w_op,
  output logic [4:0] reg_rd_adr,
  output logic [7:0] reg_rd_in,
  output logic [7:0] reg_rd_hb_in,
  output logic       flag_wr,
  output logic       sreg_c,
  output logic       sreg_z
);

  localparam int         N        = 8 / BITS_PER_CYC;
  localparam logic [3:0] CNT_LAST = 4'(N - 1);

  mul_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic        frac_q, frac_d;
  logic [15:0] res_q, res_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic        busy_q, busy_d;
  logic        wr_q, wr_d;

  mul_op_t     op_s;
  logic        sa_s, sb_s;
  logic [7:0]  a_mag_s, b_mag_s;
  logic [15:0] acc_step_s;
  logic [15:0] p_s;
  logic [15:0] result_s;

  assign op_s    = mul_op_t'(op_sel);
  assign sa_s    = is_signed_a(op_s) & op_a[7];
  assign sb_s    = is_signed_b(op_s) & op_b[7];
  assign a_mag_s = sa_s ? (8'd0 - op_a) : op_a;
  assign b_mag_s = sb_s ? (8'd0 - op_b) : op_b;

  mul_step #(
    .BITS(BITS_PER_CYC)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .slice_i(mplier_q[BITS_PER_CYC-1:0]),
    .acc_o  (acc_step_s)
  );

  // The final step's sum feeds the result so WB is entered on the last RUN edge
  assign p_s      = neg_q ? (16'd0 - acc_step_s) : acc_step_s;
  assign result_s = frac_q ? {p_s[14:0], 1'b0} : p_s;

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    frac_d   = frac_q;
    res_d    = res_q;
    c_d      = c_q;
    z_d      = z_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush && is_legal(op_s)) begin
          state_d  = ST_RUN;
          cnt_d    = 4'd0;
          acc_d    = 16'd0;
          mcand_d  = {8'd0, a_mag_s};
          mplier_d = b_mag_s;
          neg_d    = sa_s ^ sb_s;
          frac_d   = is_frac(op_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          acc_d    = acc_step_s;
          mcand_d  = mcand_q << BITS_PER_CYC;
          mplier_d = mplier_q >> BITS_PER_CYC;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_WB;
            res_d   = result_s;
            c_d     = p_s[15];
            z_d     = (result_s == 16'h0000);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    wr_d   = (state_d == ST_WB);
  end

  // State and output registers, frozen while cp2en is low
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      acc_q    <= 16'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      neg_q    <= 1'b0;
      frac_q   <= 1'b0;
      res_q    <= 16'd0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
    end else if (cp2en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      frac_q   <= frac_d;
      res_q    <= res_d;
      c_q      <= c_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = wr_q;
  assign reg_rd_wr    = wr_q;
  assign w_op         = wr_q;
  assign flag_wr      = wr_q;
  assign reg_rd_adr   = MUL_DST_ADR;
  assign reg_rd_in    = res_q[7:0];
  assign reg_rd_hb_in = res_q[15:8];
  assign sreg_c       = c_q;
  assign sreg_z       = z_q;

endmodule

// File: tb/tb_avr_mul_unit.sv
// Self-checking bench for avr_mul_unit: vector table, random ops against an
// arithmetic reference, and hand-written flush/enable/reset/latency sequences.
module tb_avr_mul_unit;

  logic       cp2 = 1'b0;
  logic       ireset, cp2en, start, flush;
  logic [2:0] op_sel;
  logic [7:0] op_a, op_b;

  logic       busy, done, reg_rd_wr, w_op, flag_wr, sreg_c, sreg_z;
  logic [4:0] reg_rd_adr;
  logic [7:0] reg_rd_in, reg_rd_hb_in;

  logic       busy1, done1, wr1, wop1, fwr1, c1, z1;
  logic [4:0] adr1;
  logic [7:0] lo1, hi1;
  logic       busy8, done8, wr8, wop8, fwr8, c8, z8;
  logic [4:0] adr8;
  logic [7:0] lo8, hi8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 cp2 = ~cp2;

  avr_mul_unit #(.BITS_PER_CYC(4)) dut (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .start(start), .flush(flush),
    .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .reg_rd_wr(reg_rd_wr), .w_op(w_op), .reg_rd_adr(reg_rd_adr),
    .reg_rd_in(reg_rd_in), .reg_rd_hb_in(reg_rd_hb_in), .flag_wr(flag_wr),
    .sreg_c(sreg_c), .sreg_z(sreg_z)
  );

  avr_mul_unit #(.BITS_PER_CYC(1)) dut1 (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .start(start), .flush(flush),
    .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1),
    .reg_rd_wr(wr1), .w_op(wop1), .reg_rd_adr(adr1),
    .reg_rd_in(lo1), .reg_rd_hb_in(hi1), .flag_wr(fwr1),
    .sreg_c(c1), .sreg_z(z1)
  );

  avr_mul_unit #(.BITS_PER_CYC(8)) dut8 (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .start(start), .flush(flush),
    .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .busy(busy8), .done(done8),
    .reg_rd_wr(wr8), .w_op(wop8), .reg_rd_adr(adr8),
    .reg_rd_in(lo8), .reg_rd_hb_in(hi8), .flag_wr(fwr8),
    .sreg_c(c8), .sreg_z(z8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge
  task automatic step();
    @(posedge cp2);
    #1;
  endtask

  // Reference: signed/unsigned integer product, fractional ops shift left by one
  function automatic logic [17:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, prod;
    logic [15:0] raw, res;
    ia   = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) ? int'($signed(a)) : int'(a);
    ib   = (op == 3'd1 || op == 3'd4) ? int'($signed(b)) : int'(b);
    prod = ia * ib;
    raw  = prod[15:0];
    res  = (op >= 3'd3) ? {raw[14:0], 1'b0} : raw;
    return {raw[15], (res == 16'h0000), res};
  endfunction

  task automatic chk_wb(input string tag, input logic [15:0] res, input logic c, input logic z);
    chk({tag, " wr"}, {reg_rd_wr, w_op, flag_wr, done}, 32'hF);
    chk({tag, " adr"}, reg_rd_adr, 32'd0);
    chk({tag, " res"}, {reg_rd_hb_in, reg_rd_in}, res);
    chk({tag, " c"}, sreg_c, c);
    chk({tag, " z"}, sreg_z, z);
  endtask

  // One full transaction on the default-width instance with cycle-exact timing checks
  task automatic run_check(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] res, input logic c, input logic z);
    op_sel = op; op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " c1 busy/wr"}, {busy, reg_rd_wr}, 32'h2);
    step();
    chk({tag, " c2 busy/wr"}, {busy, reg_rd_wr}, 32'h2);
    step();
    chk({tag, " c3 busy"}, busy, 32'd1);
    chk_wb(tag, res, c, z);
    step();
    chk({tag, " c4 busy/wr"}, {busy, reg_rd_wr, done}, 32'h0);
    chk({tag, " hold"}, {reg_rd_hb_in, reg_rd_in}, res);
  endtask

  initial begin
    logic [17:0] m;
    logic [2:0]  rop;
    logic [7:0]  ra, rb;

    ireset = 1'b0; cp2en = 1'b1; start = 1'b0; flush = 1'b0;
    op_sel = 3'd0; op_a = 8'd0; op_b = 8'd0;
    tbl[0] = '{3'd0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0};
    tbl[1] = '{3'd1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0};
    tbl[2] = '{3'd4, 8'h80, 8'h80, 16'h8000, 1'b0, 1'b0};
    tbl[3] = '{3'd2, 8'hFF, 8'hFF, 16'hFF01, 1'b1, 1'b0};
    tbl[4] = '{3'd3, 8'hC0, 8'h80, 16'hC000, 1'b0, 1'b0};
    tbl[5] = '{3'd0, 8'h00, 8'h37, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{3'd3, 8'h80, 8'h01, 16'h0100, 1'b0, 1'b0};
    tbl[7] = '{3'd2, 8'h80, 8'hFF, 16'h8080, 1'b1, 1'b0};
    tbl[8] = '{3'd1, 8'h7F, 8'h80, 16'hC080, 1'b1, 1'b0};
    tbl[9] = '{3'd5, 8'h80, 8'hFF, 16'h0100, 1'b1, 1'b0};

    #12;
    chk("reset outs", {busy, done, reg_rd_wr, w_op, flag_wr, reg_rd_adr, reg_rd_hb_in, reg_rd_in, sreg_c, sreg_z}, 32'd0);
    ireset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].c, tbl[i].z);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      m   = model(rop, ra, rb);
      run_check($sformatf("rnd%0d op%0d %h*%h", i, rop, ra, rb), rop, ra, rb, m[15:0], m[17], m[16]);
    end

    // Flush in the first RUN cycle: no write, busy drops
    op_sel = 3'd0; op_a = 8'h12; op_b = 8'h34; start = 1'b1;
    step();
    start = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", busy, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("flush no wr", {reg_rd_wr, done}, 32'd0);
      step();
    end

    // Start held during busy is ignored; result is from the first operands
    op_sel = 3'd0; op_a = 8'd3; op_b = 8'd5; start = 1'b1;
    step();
    op_a = 8'd7; op_b = 8'd9;
    step();
    step();
    chk_wb("busy start", 16'd15, 1'b0, 1'b0);
    step();
    start = 1'b0;
    chk("busy start idle", {busy, reg_rd_wr}, 32'd0);
    step();
    chk("busy start no relaunch", busy, 32'd0);

    // Reserved op: nothing happens
    op_sel = 3'b110; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rsv idle", {busy, reg_rd_wr}, 32'd0);
      step();
    end

    // cp2en low for three cycles mid-RUN delays strobes by three cycles
    op_sel = 3'd0; op_a = 8'd200; op_b = 8'd100; start = 1'b1;
    step();
    start = 1'b0; cp2en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en freeze", {busy, reg_rd_wr}, 32'h2);
    end
    cp2en = 1'b1;
    step();
    chk("en resume", {busy, reg_rd_wr}, 32'h2);
    step();
    chk_wb("en late", 16'd20000, 1'b0, 1'b0);
    cp2en = 1'b0;
    step();
    step();
    chk("en wb hold", {busy, reg_rd_wr, done}, 32'h7);
    cp2en = 1'b1;
    step();
    chk("en wb release", {busy, reg_rd_wr}, 32'd0);

    // Reset mid-RUN: immediate zero outputs and no later write
    op_sel = 3'd0; op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    ireset = 1'b0;
    #1;
    chk("rst mid run", {busy, done, reg_rd_wr, w_op, flag_wr, reg_rd_hb_in, reg_rd_in, sreg_c, sreg_z}, 32'd0);
    ireset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst no wr", {reg_rd_wr, wr1, wr8}, 32'd0);
    end

    // Latency for 1 and 8 bits per cycle, same stimulus as the first vector
    op_sel = 3'd0; op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      chk($sformatf("b1 cyc%0d wr", cyc), wr1, (cyc == 9) ? 32'd1 : 32'd0);
      chk($sformatf("b1 cyc%0d busy", cyc), busy1, (cyc <= 9) ? 32'd1 : 32'd0);
      chk($sformatf("b8 cyc%0d wr", cyc), wr8, (cyc == 2) ? 32'd1 : 32'd0);
      chk($sformatf("b8 cyc%0d busy", cyc), busy8, (cyc <= 2) ? 32'd1 : 32'd0);
      if (cyc == 9) chk("b1 res", {hi1, lo1, c1, z1}, {16'hFE01, 1'b1, 1'b0});
      if (cyc == 2) chk("b8 res", {hi8, lo8, c8, z8}, {16'hFE01, 1'b1, 1'b0});
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
